alu_m: RTL

ALU_M -- requirements
Module: alu_m

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_m_if.sv | 30 +++
 rtl/alu_m_muldiv_iter.sv | 115 +++++++++++
 rtl/alu_m_mux.sv | 15 +
 rtl/alu_m.sv | 136 +++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg -- shared encodings for the alu_m slice.
//   selectop layout : {funct7[0], funct7[5], funct3[2:0]}
//   funct3 encodings: base RV32I group and RV32M group
//   state_t         : control FSM states of alu_m
package alu_pkg;

   // Field positions inside selectop
   localparam int SEL_M      = 4;   // funct7[0]: selects the M (mul/div) group
   localparam int SEL_ALT    = 3;   // funct7[5]: SUB instead of ADD, SRA instead of SRL
   localparam int SEL_F3_MSB = 2;
   localparam int SEL_F3_LSB = 0;

   // Base group funct3
   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   // M group funct3 (bit 2 set means divide class)
   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/alu_m_if.sv
// alu_m_if -- operation/result handshake bundle for alu_m.
//   request : in_valid/in_ready, a, b, selectop, kill
//   response: out_valid/out_ready, out, eq, lt, ltu, zerof
//   master  : the side that issues operations and consumes results
//   slave   : the ALU
interface alu_m_if #(parameter int XLEN = 32);
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic [4:0]      selectop;
   logic            kill;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out;
   logic            eq;
   logic            lt;
   logic            ltu;
   logic            zerof;

   modport master (
      output in_valid, a, b, selectop, kill, out_ready,
      input  in_ready, out_valid, out, eq, lt, ltu, zerof
   );

   modport slave (
      input  in_valid, a, b, selectop, kill, out_ready,
      output in_ready, out_valid, out, eq, lt, ltu, zerof
   );
endinterface

// File: rtl/alu_m_muldiv_iter.sv
// muldiv_iter -- iterative multiply/divide datapath for alu_m.
//   start : load operands (a, b, f3) and clear the iteration counter
//   step  : perform one iteration (shift-add or restoring-subtract)
//   kill  : clear the iteration counter
//   last  : this step is the final iteration; res is valid in the same cycle
//   res   : final, sign-corrected result derived from the post-step values
// Signed operations run on magnitudes; signs are re-applied at the end.
module muldiv_iter
   import alu_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int SHW  = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            kill,
   input  logic            start,
   input  logic            step,
   input  logic [2:0]      f3,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            last,
   output logic [XLEN-1:0] res
);
   // hi:lo is the product accumulator (mul) or remainder:quotient (div).
   // dsr holds the multiplicand (mul) or the divisor (div).
   logic [XLEN-1:0] hi, lo, dsr, hi_n, lo_n;
   logic [2:0]      op;
   logic            neg_q, neg_r, bz;
   logic [SHW-1:0]  cnt;

   logic            a_sgn, b_sgn, sa, sb;
   logic [XLEN-1:0] ma, mb;

   always_comb begin
      a_sgn = (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
      b_sgn = (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
      sa    = a_sgn & a[XLEN-1];
      sb    = b_sgn & b[XLEN-1];
      ma    = sa ? -a : a;
      mb    = sb ? -b : b;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi    <= '0;
         lo    <= '0;
         dsr   <= '0;
         op    <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         bz    <= 1'b0;
         cnt   <= '0;
      end else if (kill) begin
         cnt <= '0;
      end else if (start) begin
         op    <= f3;
         neg_q <= sa ^ sb;       // product sign and quotient sign
         neg_r <= sa;            // remainder follows the dividend
         bz    <= (b == '0);
         cnt   <= '0;
         hi    <= '0;
         if (f3[2]) begin
            lo  <= ma;
            dsr <= mb;
         end else begin
            lo  <= mb;           // multiplier bits are consumed from lo[0]
            dsr <= ma;
         end
      end else if (step) begin
         hi  <= hi_n;
         lo  <= lo_n;
         cnt <= cnt + 1'b1;
      end
   end

   assign last = step & (cnt == SHW'(XLEN - 1));

   logic [XLEN:0] sum, rsh, diff;

   always_comb begin
      sum  = {1'b0, hi} + (lo[0] ? {1'b0, dsr} : '0);
      rsh  = {hi, lo[XLEN-1]};
      diff = rsh - {1'b0, dsr};
      if (!op[2]) begin
         // shift-add: {carry, hi, lo} >> 1
         hi_n = sum[XLEN:1];
         lo_n = {sum[0], lo[XLEN-1:1]};
      end else if (!diff[XLEN]) begin
         hi_n = diff[XLEN-1:0];
         lo_n = {lo[XLEN-2:0], 1'b1};
      end else begin
         hi_n = rsh[XLEN-1:0];
         lo_n = {lo[XLEN-2:0], 1'b0};
      end
   end

   logic [2*XLEN-1:0] p;
   logic [XLEN-1:0]   q, r;

   always_comb begin
      p = {hi_n, lo_n};
      if (neg_q) p = -p;
      q = neg_q ? -lo_n : lo_n;
      r = neg_r ? -hi_n : hi_n;
      case (op)
         F3_MUL:                       res = p[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU: res = p[2*XLEN-1:XLEN];
         // Zero divisor forces all-ones; the remainder path already yields a.
         F3_DIV, F3_DIVU:              res = bz ? '1 : q;
         default:                      res = r;
      endcase
   end

endmodule

// File: rtl/alu_m_mux.sv
// pmux -- generic N-way one-of-N selector.
//   din  : N packed candidates of W bits
//   sel  : index of the candidate to forward
//   dout : selected candidate
module pmux #(
   parameter int N  = 8,
   parameter int W  = 32,
   parameter int SW = $clog2(N)
) (
   input  logic [N-1:0][W-1:0] din,
   input  logic [SW-1:0]       sel,
   output logic [W-1:0]        dout
);
   assign dout = din[sel];
endmodule

// File: rtl/alu_m.sv
// alu_m -- RV32I base ALU plus iterative RV32M multiply/divide.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alu_m_if.slave
//                in_valid/in_ready, a, b, selectop, kill  -> operation request
//                out_valid/out_ready, out, eq/lt/ltu/zerof -> held result
// Base ops finish one cycle after acceptance; mul/div ops take XLEN+1.
// Results are held in DONE until consumed; a new op may be accepted in
// the same cycle the held result is consumed.
module alu_m
   import alu_pkg::*;
#(
   parameter int XLEN = 32,                // power of two, 8..64
   parameter int SHW  = $clog2(XLEN)       // derived; leave at default
) (
   input logic   clk,
   input logic   rst_n,
   alu_m_if.slave bus
);
   state_t          state, state_n, op_st;
   logic            rdy, accept, is_m, alt, start, step, last;
   logic [2:0]      f3;
   logic [SHW-1:0]  shamt;
   logic            eq_c, lt_c, ltu_c;
   logic [XLEN-1:0] base_res, iter_res;

   assign f3    = bus.selectop[SEL_F3_MSB:SEL_F3_LSB];
   assign alt   = bus.selectop[SEL_ALT];
   assign is_m  = bus.selectop[SEL_M];
   assign shamt = bus.b[SHW-1:0];

   assign eq_c  = (bus.a == bus.b);
   assign lt_c  = ($signed(bus.a) < $signed(bus.b));
   assign ltu_c = (bus.a < bus.b);

   // ---------------- base ALU ----------------
   logic [7:0][XLEN-1:0]   cand;
   logic signed [XLEN-1:0] sra_v;

   always_comb begin
      // kept as its own signed statement so the shift stays arithmetic
      sra_v         = $signed(bus.a) >>> shamt;
      cand          = '0;
      cand[F3_ADD]  = alt ? (bus.a - bus.b) : (bus.a + bus.b);
      cand[F3_SLL]  = bus.a << shamt;
      cand[F3_SLT]  = {{(XLEN-1){1'b0}}, lt_c};
      cand[F3_SLTU] = {{(XLEN-1){1'b0}}, ltu_c};
      cand[F3_XOR]  = bus.a ^ bus.b;
      cand[F3_SR]   = alt ? sra_v : (bus.a >> shamt);
      cand[F3_OR]   = bus.a | bus.b;
      cand[F3_AND]  = bus.a & bus.b;
   end

   pmux #(.N(8), .W(XLEN)) u_mux (
      .din  (cand),
      .sel  (f3),
      .dout (base_res)
   );

   // ---------------- control FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      rdy     = ~bus.kill & ((state == IDLE) | ((state == DONE) & bus.out_ready));
      accept  = bus.in_valid & rdy;
      op_st   = !is_m ? DONE : (f3[2] ? DIV : MUL);
      case (state)
         IDLE:     if (accept) state_n = op_st;
         MUL, DIV: if (last)   state_n = DONE;
         DONE:     if (bus.out_ready) state_n = accept ? op_st : IDLE;
         default:  state_n = IDLE;
      endcase
      if (bus.kill) state_n = IDLE;
   end

   assign start = accept & is_m;
   assign step  = ((state == MUL) | (state == DIV)) & ~bus.kill;

   muldiv_iter #(.XLEN(XLEN), .SHW(SHW)) u_iter (
      .clk   (clk),
      .rst_n (rst_n),
      .kill  (bus.kill),
      .start (start),
      .step  (step),
      .f3    (f3),
      .a     (bus.a),
      .b     (bus.b),
      .last  (last),
      .res   (iter_res)
   );

   // ---------------- result / flag registers ----------------
   // Compare flags are taken at acceptance and parked until the
   // iterative result lands, so later operand changes cannot leak in.
   logic [2:0]      fpend;
   logic [XLEN-1:0] out_q;
   logic            eq_q, lt_q, ltu_q, zf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fpend <= '0;
         out_q <= '0;
         eq_q  <= 1'b0;
         lt_q  <= 1'b0;
         ltu_q <= 1'b0;
         zf_q  <= 1'b0;
      end else begin
         if (accept) fpend <= {eq_c, lt_c, ltu_c};
         if (accept & ~is_m) begin
            out_q <= base_res;
            eq_q  <= eq_c;
            lt_q  <= lt_c;
            ltu_q <= ltu_c;
            zf_q  <= (base_res == '0);
         end else if (last) begin
            out_q              <= iter_res;
            {eq_q, lt_q, ltu_q} <= fpend;
            zf_q               <= (iter_res == '0);
         end
      end
   end

   // in_ready is masked by rst_n only at the port; internally the FSM is
   // already held in IDLE by the asynchronous reset.
   assign bus.in_ready  = rdy & rst_n;
   assign bus.out_valid = (state == DONE);
   assign bus.out       = out_q;
   assign bus.eq        = eq_q;
   assign bus.lt        = lt_q;
   assign bus.ltu       = ltu_q;
   assign bus.zerof     = zf_q;

endmodule
